ps2_cmd_seq: RTL

Parametrised PS/2 host command sequencer that generalises the single-purpose reset handshake. It sends any mouse command byte, with an optional argument byte (e.g. F3 sample rate), and checks ACK (FA) after each byte. It retries on Resend (FE), enforces a timeout, and then collects a programmable number of response bytes. It sits between the mouse init/control FSM and the PS/2 tx/rx PHY.

---
 rtl/ps2_pkg.sv | 34 +++
 rtl/ps2_timeout_cnt.sv | 31 +++
 rtl/ps2_cmd_seq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, error codes and state encoding for the PS/2 command sequencer.
// Optional BAT response check: define PS2_CMD_SEQ_BAT_CHECK_EN.
package ps2_pkg;

  localparam logic [7:0] CMD_RESET        = 8'hFF;
  localparam logic [7:0] CMD_ENABLE       = 8'hF4;
  localparam logic [7:0] CMD_SET_RATE     = 8'hF3;
  localparam logic [7:0] CMD_SET_DEFAULTS = 8'hF6;

  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_ERROR  = 8'hFC;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_RETRIES = 2'd2;
  localparam logic [1:0] ERR_MOUSE   = 2'd3;

  localparam logic PH_CMD = 1'b0;
  localparam logic PH_ARG = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_TX,
    S_WAIT_ACK,
    S_WAIT_RESP,
    S_DONE,
    S_FAIL
  } state_t;

endpackage

// File: rtl/ps2_timeout_cnt.sv
// Per-wait-state timeout counter: expires after TIMEOUT_CYCLES enabled cycles.
// Cleared by the sequencer on state entry and on accepted rx bytes.
module ps2_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_cnt;

  assign o_expired = i_en && (r_cnt == LAST);

  // count enabled cycles, hold at the expiry value until cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_cmd_seq.sv
// PS/2 host command sequencer: send cmd (+arg), check ACK, retry, collect responses.
// Optional BAT check on reset responses: define PS2_CMD_SEQ_BAT_CHECK_EN.
module ps2_cmd_seq
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int MAX_RETRIES    = 3,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] cmd,
  input  logic       has_arg,
  input  logic [7:0] arg,
  input  logic [1:0] n_resp,
  input  logic [7:0] rx_data,
  input  logic       rx_done_tick,
  input  logic       tx_done_tick,
  output logic       wr_ps2,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       resp_valid,
  output logic [7:0] resp_byte,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int RT_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [RT_W-1:0] RT_MAX = RT_W'(MAX_RETRIES);

  state_t          r_state;
  state_t          w_nstate;
  logic            r_phase;
  logic            w_nphase;
  logic [7:0]      r_cmd;
  logic [7:0]      r_arg;
  logic            r_has_arg;
  logic [1:0]      r_n_resp;
  logic [RT_W-1:0] r_retry;
  logic [1:0]      r_resp_cnt;
  logic [7:0]      r_tx_data;
  logic            r_resp_valid;
  logic [7:0]      r_resp_byte;
  logic [1:0]      r_err_code;

  logic       w_retry_inc;
  logic       w_retry_clr;
  logic       w_resend;
  logic       w_rx_acc;
  logic       w_resp_fire;
  logic [1:0] w_code;
  logic       w_to_clr;
  logic       w_to_en;
  logic       w_to_exp;
  logic       w_bat_bad;
  logic [7:0] w_tx_nxt;

  ps2_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_to (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_to_clr),
    .i_en     (w_to_en),
    .o_expired(w_to_exp)
  );

`ifdef PS2_CMD_SEQ_BAT_CHECK_EN
  assign w_bat_bad = (r_cmd == CMD_RESET) &&
    (((r_resp_cnt == 2'd0) && (rx_data != RSP_BAT_OK)) ||
     ((r_resp_cnt == 2'd1) && (rx_data != RSP_ID)));
`else
  assign w_bat_bad = 1'b0;
`endif

  assign w_to_en = (r_state == S_WAIT_TX) ||
                   (r_state == S_WAIT_ACK) ||
                   (r_state == S_WAIT_RESP);
  assign w_to_clr = (w_nstate != r_state) || w_rx_acc;

  assign w_tx_nxt = (w_nphase == PH_ARG) ? r_arg :
                    (r_state == S_IDLE) ? cmd : r_cmd;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nstate;
    end
  end

  // next-state and control strobes
  always_comb begin
    w_nstate    = r_state;
    w_nphase    = r_phase;
    w_retry_inc = 1'b0;
    w_retry_clr = 1'b0;
    w_resend    = 1'b0;
    w_rx_acc    = 1'b0;
    w_resp_fire = 1'b0;
    w_code      = ERR_NONE;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nstate    = S_SEND;
          w_nphase    = PH_CMD;
          w_retry_clr = 1'b1;
        end
      end
      S_SEND: begin
        w_nstate = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (tx_done_tick) begin
          w_nstate = S_WAIT_ACK;
        end else if (w_to_exp) begin
          w_nstate = S_FAIL;
          w_code   = ERR_TIMEOUT;
        end
      end
      S_WAIT_ACK: begin
        if (rx_done_tick) begin
          w_rx_acc = 1'b1;
          if (rx_data == RSP_ACK) begin
            w_retry_clr = 1'b1;
            if ((r_phase == PH_CMD) && r_has_arg) begin
              w_nphase = PH_ARG;
              w_nstate = S_SEND;
            end else if (r_n_resp == 2'd0) begin
              w_nstate = S_DONE;
            end else begin
              w_nstate = S_WAIT_RESP;
            end
          end else if (rx_data == RSP_RESEND) begin
            w_resend = 1'b1;
          end else if (rx_data == RSP_ERROR) begin
            w_nstate = S_FAIL;
            w_code   = ERR_MOUSE;
          end
        end else if (w_to_exp) begin
          w_resend = 1'b1;
        end
        if (w_resend) begin
          if (r_retry < RT_MAX) begin
            w_retry_inc = 1'b1;
            w_nstate    = S_SEND;
          end else begin
            w_nstate = S_FAIL;
            w_code   = ERR_RETRIES;
          end
        end
      end
      S_WAIT_RESP: begin
        if (rx_done_tick) begin
          w_rx_acc    = 1'b1;
          w_resp_fire = 1'b1;
          if (w_bat_bad) begin
            w_nstate = S_FAIL;
            w_code   = ERR_MOUSE;
          end else if ((r_resp_cnt + 2'd1) == r_n_resp) begin
            w_nstate = S_DONE;
          end
        end else if (w_to_exp) begin
          w_nstate = S_FAIL;
          w_code   = ERR_TIMEOUT;
        end
      end
      S_DONE: begin
        w_nstate = S_IDLE;
      end
      S_FAIL: begin
        w_nstate = S_IDLE;
      end
      default: begin
        w_nstate = S_IDLE;
      end
    endcase
  end

  // request latches, retry/response counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase      <= PH_CMD;
      r_cmd        <= '0;
      r_arg        <= '0;
      r_has_arg    <= 1'b0;
      r_n_resp     <= '0;
      r_retry      <= '0;
      r_resp_cnt   <= '0;
      r_tx_data    <= '0;
      r_resp_valid <= 1'b0;
      r_resp_byte  <= '0;
      r_err_code   <= ERR_NONE;
    end else begin
      r_phase      <= w_nphase;
      r_resp_valid <= w_resp_fire;
      if ((r_state == S_IDLE) && start) begin
        r_cmd      <= cmd;
        r_arg      <= arg;
        r_has_arg  <= has_arg;
        r_n_resp   <= n_resp;
        r_resp_cnt <= '0;
        r_err_code <= ERR_NONE;
      end
      if (w_retry_clr) begin
        r_retry <= '0;
      end else if (w_retry_inc) begin
        r_retry <= r_retry + 1'b1;
      end
      if (w_nstate == S_SEND) begin
        r_tx_data <= w_tx_nxt;
      end
      if (w_resp_fire) begin
        r_resp_byte <= rx_data;
        r_resp_cnt  <= r_resp_cnt + 2'd1;
      end
      if (w_nstate == S_FAIL) begin
        r_err_code <= w_code;
      end
    end
  end

  assign wr_ps2     = (r_state == S_SEND);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign err        = (r_state == S_FAIL);
  assign tx_data    = r_tx_data;
  assign resp_valid = r_resp_valid;
  assign resp_byte  = r_resp_byte;
  assign err_code   = r_err_code;

endmodule
